// File: rtl/rst_sequencer.sv
// rst_sequencer: staged reset release for interconnect, peripherals and core.
// Inputs are synchronized and debounced; aborts are counted and their cause recorded.
module rst_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STAGE_GAP       = 16
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       ext_reset_in,
    input  logic       dcm_locked,
    input  logic       sw_reset_req,
    output logic       bus_struct_reset,
    output logic       interconnect_aresetn,
    output logic       peripheral_reset,
    output logic       peripheral_aresetn,
    output logic       mb_reset,
    output logic       rst_done,
    output logic [1:0] rst_cause,
    output logic [7:0] abort_count
);

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        BUS    = 2'd1,
        PERIPH = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        ext_meta;
    logic        ext_sync;
    logic        lock_meta;
    logic        lock_sync;
    logic [15:0] deb_cnt;
    logic [15:0] deb_nx;
    logic [15:0] gap_cnt;
    logic [15:0] gap_nx;
    logic [1:0]  cause_nx;
    logic [7:0]  aborts_nx;
    logic        bus_nx;
    logic        periph_nx;
    logic        mb_nx;
    logic        done_nx;
    logic        qualified;
    logic        lock_lost;
    logic        abort;

    // Sync reset values pick the safe side: button pressed, clock unlocked.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            ext_meta  <= 1'b1;
            ext_sync  <= 1'b1;
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            ext_meta  <= ext_reset_in;
            ext_sync  <= ext_meta;
            lock_meta <= dcm_locked;
            lock_sync <= lock_meta;
        end
    end

    always_comb begin
        qualified = ~ext_sync & lock_sync;
        lock_lost = ~lock_sync;
        abort     = (state != HOLD) &
                    (lock_lost | ext_sync | sw_reset_req);
        state_nx  = state;
        deb_nx    = '0;
        gap_nx    = '0;
        cause_nx  = rst_cause;
        aborts_nx = abort_count;

        unique case (state)
            HOLD: begin
                if (qualified && !sw_reset_req) begin
                    if (deb_cnt == DEB_LAST)
                        state_nx = BUS;
                    else
                        deb_nx = deb_cnt + 16'd1;
                end
            end
            BUS: begin
                if (gap_cnt == GAP_LAST)
                    state_nx = PERIPH;
                else
                    gap_nx = gap_cnt + 16'd1;
            end
            PERIPH: begin
                if (gap_cnt == GAP_LAST)
                    state_nx = RUN;
                else
                    gap_nx = gap_cnt + 16'd1;
            end
            RUN: state_nx = RUN;
            default: state_nx = HOLD;
        endcase

        // Abort overrides any stage timeout taken above.
        if (abort) begin
            state_nx = HOLD;
            gap_nx   = '0;
            if (lock_lost)
                cause_nx = 2'b10;
            else if (ext_sync)
                cause_nx = 2'b01;
            else
                cause_nx = 2'b11;
            if (abort_count != 8'hFF)
                aborts_nx = abort_count + 8'd1;
        end

        bus_nx    = (state_nx == HOLD);
        periph_nx = (state_nx == HOLD) || (state_nx == BUS);
        mb_nx     = (state_nx != RUN);
        done_nx   = (state_nx == RUN);
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state            <= HOLD;
            deb_cnt          <= '0;
            gap_cnt          <= '0;
            rst_cause        <= 2'b00;
            abort_count      <= 8'd0;
            bus_struct_reset <= 1'b1;
            peripheral_reset <= 1'b1;
            mb_reset         <= 1'b1;
            rst_done         <= 1'b0;
        end else begin
            state            <= state_nx;
            deb_cnt          <= deb_nx;
            gap_cnt          <= gap_nx;
            rst_cause        <= cause_nx;
            abort_count      <= aborts_nx;
            bus_struct_reset <= bus_nx;
            peripheral_reset <= periph_nx;
            mb_reset         <= mb_nx;
            rst_done         <= done_nx;
        end
    end

    assign interconnect_aresetn = ~bus_struct_reset;
    assign peripheral_aresetn   = ~peripheral_reset;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: level-based release model checked every cycle,
// plus directed scenarios with hand-computed edge expectations.
module tb_rst_sequencer;

    localparam int D = 4;
    localparam int G = 3;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       ext_reset_in;
    logic       dcm_locked;
    logic       sw_reset_req;
    logic       bus_struct_reset;
    logic       interconnect_aresetn;
    logic       peripheral_reset;
    logic       peripheral_aresetn;
    logic       mb_reset;
    logic       rst_done;
    logic [1:0] rst_cause;
    logic [7:0] abort_count;

    int checks = 0;
    int errors = 0;

    rst_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .STAGE_GAP      (G)
    ) dut (
        .sys_clock           (sys_clock),
        .reset               (reset),
        .ext_reset_in        (ext_reset_in),
        .dcm_locked          (dcm_locked),
        .sw_reset_req        (sw_reset_req),
        .bus_struct_reset    (bus_struct_reset),
        .interconnect_aresetn(interconnect_aresetn),
        .peripheral_reset    (peripheral_reset),
        .peripheral_aresetn  (peripheral_aresetn),
        .mb_reset            (mb_reset),
        .rst_done            (rst_done),
        .rst_cause           (rst_cause),
        .abort_count         (abort_count)
    );

    always #5 sys_clock = ~sys_clock;

    logic s_rst, s_ext, s_lock, s_sw;

    always @(posedge sys_clock) begin
        s_rst  <= reset;
        s_ext  <= ext_reset_in;
        s_lock <= dcm_locked;
        s_sw   <= sw_reset_req;
    end

    // Model: release level 0..3, good-input streak, time spent at level,
    // and two-deep input histories standing in for the synchronizers.
    int         m_level  = 0;
    int         m_streak = 0;
    int         m_tin    = 0;
    int         m_aborts = 0;
    logic [1:0] m_cause  = 2'b00;
    logic       e1, e2, l1, l2;
    bit         m_valid  = 1'b0;
    logic [15:0] exp_v, got_v;

    always @(negedge sys_clock) begin
        if (s_rst === 1'b1) begin
            m_level  = 0;
            m_streak = 0;
            m_tin    = 0;
            m_aborts = 0;
            m_cause  = 2'b00;
            e1 = 1'b1; e2 = 1'b1;
            l1 = 1'b0; l2 = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            if (m_level == 0) begin
                if (!e2 && l2 && !s_sw) begin
                    if (m_streak == D - 1) begin
                        m_level  = 1;
                        m_streak = 0;
                        m_tin    = 0;
                    end else begin
                        m_streak++;
                    end
                end else begin
                    m_streak = 0;
                end
            end else if (!l2 || e2 || s_sw) begin
                m_cause  = !l2 ? 2'b10 : (e2 ? 2'b01 : 2'b11);
                if (m_aborts < 255) m_aborts++;
                m_level  = 0;
                m_streak = 0;
                m_tin    = 0;
            end else if (m_level < 3) begin
                m_tin++;
                if (m_tin == G) begin
                    m_level++;
                    m_tin = 0;
                end
            end
            e2 = e1; e1 = s_ext;
            l2 = l1; l1 = s_lock;
        end
        if (m_valid) begin
            exp_v = {m_level == 0, m_level != 0,
                     m_level < 2, m_level >= 2,
                     m_level < 3, m_level == 3,
                     m_cause, 8'(m_aborts)};
            got_v = {bus_struct_reset, interconnect_aresetn,
                     peripheral_reset, peripheral_aresetn,
                     mb_reset, rst_done, rst_cause, abort_count};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL model t=%0t got %b expected %b",
                         $time, got_v, exp_v);
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge sys_clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " bus"},     bus_struct_reset, 1);
        chk({tag, " ic_n"},    interconnect_aresetn, 0);
        chk({tag, " per"},     peripheral_reset, 1);
        chk({tag, " per_n"},   peripheral_aresetn, 0);
        chk({tag, " mb"},      mb_reset, 1);
        chk({tag, " done"},    rst_done, 0);
        chk({tag, " cause"},   rst_cause, 0);
        chk({tag, " aborts"},  abort_count, 0);
    endtask

    initial begin
        reset        = 1'b1;
        ext_reset_in = 1'b0;
        dcm_locked   = 1'b1;
        sw_reset_req = 1'b0;

        // Power-up: edge 0 is the last edge with reset high
        ticks(3);
        chk_reset_vals("por");
        reset = 1'b0;
        ticks(5);
        chk("pu bus e5", bus_struct_reset, 1);
        ticks(1);
        chk("pu bus e6", bus_struct_reset, 0);
        chk("pu per e6", peripheral_reset, 1);
        ticks(3);
        chk("pu per e9", peripheral_reset, 0);
        chk("pu mb e9", mb_reset, 1);
        ticks(2);
        chk("pu mb e11", mb_reset, 1);
        ticks(1);
        chk("pu mb e12", mb_reset, 0);
        chk("pu done e12", rst_done, 1);
        chk("pu cause", rst_cause, 0);

        // Software reset in RUN
        sw_reset_req = 1'b1;
        ticks(1);
        sw_reset_req = 1'b0;
        chk("sw bus", bus_struct_reset, 1);
        chk("sw done", rst_done, 0);
        chk("sw cause", rst_cause, 2'b11);
        chk("sw aborts", abort_count, 1);
        ticks(3);
        chk("sw bus +3", bus_struct_reset, 1);
        ticks(1);
        chk("sw bus +4", bus_struct_reset, 0);
        ticks(6);
        chk("sw done +10", rst_done, 1);

        // External reset and software request seen on the same cycle
        ext_reset_in = 1'b1;
        ticks(2);
        chk("sim done early", rst_done, 1);
        sw_reset_req = 1'b1;
        ticks(1);
        sw_reset_req = 1'b0;
        ext_reset_in = 1'b0;
        chk("sim bus", bus_struct_reset, 1);
        chk("sim cause", rst_cause, 2'b01);
        chk("sim aborts", abort_count, 2);
        ticks(2);
        chk("sim cause hold", rst_cause, 2'b01);
        ticks(20);
        chk("sim done", rst_done, 1);

        // Lock loss while in PERIPH
        sw_reset_req = 1'b1;
        ticks(1);
        sw_reset_req = 1'b0;
        ticks(7);
        chk("lk per", peripheral_reset, 0);
        chk("lk mb", mb_reset, 1);
        dcm_locked = 1'b0;
        ticks(2);
        chk("lk per +2", peripheral_reset, 0);
        ticks(1);
        chk("lk bus +3", bus_struct_reset, 1);
        chk("lk per +3", peripheral_reset, 1);
        chk("lk cause", rst_cause, 2'b10);
        chk("lk aborts", abort_count, 4);
        dcm_locked = 1'b1;
        ticks(20);
        chk("lk done", rst_done, 1);

        // One-cycle button glitch during debounce
        sw_reset_req = 1'b1;
        ticks(1);
        sw_reset_req = 1'b0;
        ticks(1);
        ext_reset_in = 1'b1;
        ticks(1);
        ext_reset_in = 1'b0;
        ticks(2);
        chk("gl bus +4", bus_struct_reset, 1);
        ticks(3);
        chk("gl bus +7", bus_struct_reset, 1);
        ticks(1);
        chk("gl bus +8", bus_struct_reset, 0);

        // Software request while already holding
        sw_reset_req = 1'b1;
        ticks(1);
        sw_reset_req = 1'b0;
        ticks(1);
        sw_reset_req = 1'b1;
        ticks(1);
        sw_reset_req = 1'b0;
        chk("hs cause", rst_cause, 2'b11);
        chk("hs aborts", abort_count, 6);
        ticks(3);
        chk("hs bus +5", bus_struct_reset, 1);
        ticks(1);
        chk("hs bus +6", bus_struct_reset, 0);

        // 300 more aborts saturate the counter
        repeat (300) begin
            sw_reset_req = 1'b1;
            ticks(1);
            sw_reset_req = 1'b0;
            ticks(4);
        end
        chk("sat aborts", abort_count, 255);
        chk("sat bus", bus_struct_reset, 0);
        chk("sat per", peripheral_reset, 1);

        // Reset asserted while in BUS
        reset = 1'b1;
        ticks(1);
        chk_reset_vals("bus rst");
        ticks(1);
        reset = 1'b0;
        begin
            int n;
            n = 0;
            while (rst_done !== 1'b1 && n < 40) begin
                ticks(1);
                n++;
            end
            chk("rerun done", rst_done, 1);
            chk("rerun edges", n, 12);
        end

        ticks(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive qualified-release cycles required before leaving HOLD (legal 1..65535).
REQ-002 The block SHALL have parameter STAGE_GAP, default 16: cycles spent in each intermediate release stage (legal 1..65535).
REQ-003 Port sys_clock, input, 1: the single clock, from which all logic is clocked.
REQ-004 Port reset, input, 1: reset, synchronous and active-high.
REQ-005 Port ext_reset_in, input, 1: board reset button, active-high, asynchronous to sys_clock.
REQ-006 Port dcm_locked, input, 1: clock-generator lock indication, asynchronous to sys_clock.
REQ-007 Port sw_reset_req, input, 1: single-cycle software reset request, synchronous to sys_clock.
REQ-008 Port bus_struct_reset, output, 1: interconnect reset, active-high.
REQ-009 Port interconnect_aresetn, output, 1: interconnect reset, active-low.
REQ-010 Port peripheral_reset, output, 1: peripheral reset, active-high.
REQ-011 Port peripheral_aresetn, output, 1: peripheral reset, active-low.
REQ-012 Port mb_reset, output, 1: core reset, active-high.
REQ-013 Port rst_done, output, 1: high only when all domains are released.
REQ-014 Port rst_cause, output, 2: cause of the last entry into HOLD.
REQ-015 Port abort_count, output, 8: saturating count of reset aborts since reset.

Function
REQ-016 ext_reset_in and dcm_locked SHALL each pass through a 2-flop synchronizer; the synchronizer reset values are 1 for ext_reset_in and 0 for dcm_locked.
REQ-017 Qualified-release SHALL mean synced ext_reset_in = 0 AND synced dcm_locked = 1.
REQ-018 The FSM SHALL have four states, HOLD, BUS, PERIPH and RUN; its reset state is HOLD.
REQ-019 In HOLD, a 16-bit counter SHALL increment on each qualified-release cycle without sw_reset_req, and SHALL clear on any other cycle.
REQ-020 HOLD->BUS SHALL occur on the edge where the counter equals DEBOUNCE_CYCLES-1 and the cycle is qualified-release.
REQ-021 BUS->PERIPH and PERIPH->RUN SHALL each occur after exactly STAGE_GAP cycles in the state, timed by a gap counter cleared on state entry.
REQ-022 From BUS, PERIPH or RUN, any of synced dcm_locked = 0, synced ext_reset_in = 1 or sw_reset_req = 1 SHALL force HOLD on the next edge (abort), taking priority over the stage timeout.
REQ-023 Outputs SHALL be registered and SHALL update on the same edge as the state register.
REQ-024 Outputs per state SHALL be as follows (1 = asserted, active-low ports inverted accordingly):
- HOLD: bus, peripheral and core all asserted.
- BUS: bus released; peripheral and core asserted.
- PERIPH: bus and peripheral released; core asserted.
- RUN: all released, rst_done = 1.
REQ-025 interconnect_aresetn SHALL always equal NOT bus_struct_reset, and peripheral_aresetn SHALL always equal NOT peripheral_reset.
REQ-026 rst_cause SHALL be loaded on each abort:
- 10 for lock loss.
- 01 for external reset.
- 11 for software request.
- Priority when simultaneous: lock loss > external > software.
REQ-027 Aborts SHALL NOT alter rst_cause when the FSM is already in HOLD.
REQ-028 abort_count SHALL increment by 1 on each abort and saturate at 255.
REQ-029 sw_reset_req in HOLD SHALL restart the debounce counter, so the core is held for at least DEBOUNCE_CYCLES more cycles.

Reset
REQ-030 While reset = 1, the state SHALL be HOLD, with bus_struct_reset = 1, interconnect_aresetn = 0, peripheral_reset = 1, peripheral_aresetn = 0, mb_reset = 1 and rst_done = 0.
REQ-031 While reset = 1, rst_cause SHALL be 00, abort_count SHALL be 0, all counters SHALL be 0 and synchronizers SHALL be at their REQ-016 values.
REQ-032 Reset asserted in any state SHALL return all outputs to their REQ-030 values on the next edge.

Verification (DEBOUNCE_CYCLES = 4, STAGE_GAP = 3)
REQ-033 Power-up: locked = 1 and ext = 0 held, reset dropped at edge 0 -> bus released at edge 6, peripheral released at edge 9, core released and rst_done = 1 at edge 12, rst_cause = 00.
REQ-034 Button glitch: ext_reset_in pulsed high for 1 cycle during HOLD counting -> the counter restarts and the BUS entry is delayed by the glitch position plus 4 cycles; no output toggles early.
REQ-035 Lock loss in PERIPH: dcm_locked dropped -> HOLD 3 edges after the drop (2 sync + 1), all resets asserted, rst_cause = 10, abort_count = 1.
REQ-036 Simultaneous sources: in RUN, sw_reset_req = 1 on the same cycle synced ext goes high -> rst_cause = 01, abort_count increments once.
REQ-037 Software reset: sw_reset_req pulsed in RUN -> HOLD next edge, rst_cause = 11, full sequence re-runs (bus released 4 edges later).
REQ-038 Saturation and mid-sequence reset: 300 software aborts -> abort_count = 255; reset asserted in BUS -> REQ-030 and REQ-031 values on the next edge.
